// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - sequential post-add normalizer and RNE rounder for packed IEEE-754 results
// Optional build macro FP_NORM_LZC_EN: single-cycle leading-zero-count normalization instead of bit-serial shifting.
module fp_normalize_round #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic [EXP_W-1:0]        in_exp,
   input  logic [FRAC_W+1:0]       in_mant,
   input  logic [2:0]              in_grs,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   out_result,
   output logic                    out_overflow,
   output logic                    out_underflow,
   output logic                    out_inexact
);
   localparam int XW   = EXP_W + 2;
   localparam int EMAX = (1 << EXP_W) - 1;
   localparam int VW   = FRAC_W + 3;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;
   state_t state;

   logic              sign_r;
   logic [XW-1:0]     exp_r;
   logic [FRAC_W:0]   mant_r;
   logic              g_r, r_r, s_r;

   assign in_ready = (state == S_IDLE);

   // Normalization step: the carry bit is resolved at accept, so mant_r holds hidden + fraction only.
   logic [FRAC_W:0]   sh_mant;
   logic [XW-1:0]     sh_exp;
   logic              sh_g, sh_r, sh_done;
`ifdef FP_NORM_LZC_EN
   logic [VW-1:0]     vec, shv;
   logic [XW-1:0]     lzc, lim, shamt;
   logic              found;
   always_comb begin
      vec   = {mant_r, g_r, r_r};
      lzc   = XW'(VW);
      found = 1'b0;
      for (int i = VW - 1; i >= 0; i--) begin
         if (vec[i] && !found) begin
            lzc   = XW'(VW - 1 - i);
            found = 1'b1;
         end
      end
      lim     = exp_r - XW'(1);
      shamt   = (lzc < lim) ? lzc : lim;
      shv     = vec << shamt;
      sh_mant = shv[VW-1:2];
      sh_g    = shv[1];
      sh_r    = shv[0];
      sh_exp  = exp_r - shamt;
      sh_done = 1'b1;
   end
`else
   always_comb begin
      sh_mant = {mant_r[FRAC_W-1:0], g_r};
      sh_g    = r_r;
      sh_r    = 1'b0;
      sh_exp  = exp_r - XW'(1);
      sh_done = mant_r[FRAC_W-1] || (sh_exp == XW'(1));
   end
`endif

   logic              inc;
   logic [FRAC_W+1:0] sum;
   logic [FRAC_W:0]   rmant;
   logic [XW-1:0]     rexp;
   logic [EXP_W-1:0]  rexp_field;
   logic [FRAC_W-1:0] rfrac;
   logic              rovf, runf, rinx;
   always_comb begin
      inc   = g_r & (r_r | s_r | mant_r[0]);
      sum   = {1'b0, mant_r} + {{(FRAC_W+1){1'b0}}, inc};
      rmant = sum[FRAC_W:0];
      rexp  = exp_r;
      if (sum[FRAC_W+1]) begin
         rmant = {1'b1, {FRAC_W{1'b0}}};
         rexp  = exp_r + XW'(1);
      end
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      if (rmant[FRAC_W] && (rexp == '0))
         rexp = XW'(1);
      rovf       = 1'b0;
      runf       = 1'b0;
      rinx       = g_r | r_r | s_r;
      rexp_field = rexp[EXP_W-1:0];
      rfrac      = rmant[FRAC_W-1:0];
      if (rexp >= XW'(EMAX)) begin
         rovf       = 1'b1;
         rexp_field = '1;
         rfrac      = '0;
      end else if (!rmant[FRAC_W]) begin
         rexp_field = '0;
         runf       = |rmant;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
         sign_r        <= 1'b0;
         exp_r         <= '0;
         mant_r        <= '0;
         g_r           <= 1'b0;
         r_r           <= 1'b0;
         s_r           <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               sign_r <= in_sign;
               exp_r  <= {2'b00, in_exp};
               mant_r <= in_mant[FRAC_W:0];
               g_r    <= in_grs[2];
               r_r    <= in_grs[1];
               s_r    <= in_grs[0];
               if (in_exp == '1) begin
                  out_result    <= {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                  out_overflow  <= 1'b1;
                  out_underflow <= 1'b0;
                  out_inexact   <= 1'b0;
                  out_valid     <= 1'b1;
                  state         <= S_DONE;
               end else if ((in_mant == '0) && (in_grs == 3'b000)) begin
                  out_result    <= {in_sign, {(EXP_W+FRAC_W){1'b0}}};
                  out_overflow  <= 1'b0;
                  out_underflow <= 1'b0;
                  out_inexact   <= 1'b0;
                  out_valid     <= 1'b1;
                  state         <= S_DONE;
               end else if (in_mant[FRAC_W+1]) begin
                  mant_r <= in_mant[FRAC_W+1:1];
                  exp_r  <= {2'b00, in_exp} + XW'(1);
                  g_r    <= in_mant[0];
                  r_r    <= in_grs[2];
                  s_r    <= in_grs[1] | in_grs[0];
                  state  <= S_ROUND;
               end else if (in_mant[FRAC_W] || (in_exp <= EXP_W'(1))) begin
                  // exp 1 cannot shift further, so it rounds directly like exp 0.
                  state <= S_ROUND;
               end else begin
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               mant_r <= sh_mant;
               exp_r  <= sh_exp;
               g_r    <= sh_g;
               r_r    <= sh_r;
               if (sh_done)
                  state <= S_ROUND;
            end
            S_ROUND: begin
               out_result    <= {sign_r, rexp_field, rfrac};
               out_overflow  <= rovf;
               out_underflow <= runf;
               out_inexact   <= rinx;
               out_valid     <= 1'b1;
               state         <= S_DONE;
            end
            S_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed vector bench for fp_normalize_round
module tb_fp_normalize_round;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [24:0] in_mant = '0;
   logic [2:0]  in_grs = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_inexact;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef FP_NORM_LZC_EN
   localparam bit LZC = 1'b1;
`else
   localparam bit LZC = 1'b0;
`endif

   always #5 clk = ~clk;

   fp_normalize_round #(.EXP_W(8), .FRAC_W(23)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
   );

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic [2:0]  grs;
      logic [31:0] result;
      logic [2:0]  flags;   // {overflow, underflow, inexact}
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic int shift_lat(input int k);
      return LZC ? 3 : k + 2;
   endfunction

   task automatic start_op(input vec_t v);
      @(negedge clk);
      in_sign  = v.sign;
      in_exp   = v.exp;
      in_mant  = v.mant;
      in_grs   = v.grs;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      @(negedge clk);
      check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
      start_op(v);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d result", idx), out_result, v.result);
      check($sformatf("v%0d flags", idx), 32'({out_overflow, out_underflow, out_inexact}), 32'(v.flags));
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      vec_t v;
      int cyc;
      vecs.push_back('{1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000, 2});
      vecs.push_back('{1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 3'b000, shift_lat(23)});
      vecs.push_back('{1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 32'h40000000, 3'b001, 2});
      vecs.push_back('{1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001, 2});
      vecs.push_back('{1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b100, 2});
      vecs.push_back('{1'b1, 8'd127, 25'h0000000, 3'b000, 32'h80000000, 3'b000, 1});
      vecs.push_back('{1'b0, 8'd2,   25'h0200000, 3'b000, 32'h00400000, 3'b010, shift_lat(1)});
      vecs.push_back('{1'b1, 8'd255, 25'h0123456, 3'b101, 32'hFF800000, 3'b100, 1});
      vecs.push_back('{1'b0, 8'd0,   25'h07FFFFF, 3'b110, 32'h00800000, 3'b001, 2});
      vecs.push_back('{1'b0, 8'd100, 25'h1000001, 3'b000, 32'h32800000, 3'b001, 2});
      vecs.push_back('{1'b0, 8'd100, 25'h1000003, 3'b000, 32'h32800002, 3'b001, 2});
      vecs.push_back('{1'b0, 8'd254, 25'h0FFFFFF, 3'b100, 32'h7F800000, 3'b101, 2});
      vecs.push_back('{1'b0, 8'd127, 25'h0400000, 3'b110, 32'h3F000002, 3'b001, shift_lat(1)});
      vecs.push_back('{1'b1, 8'd130, 25'h0C00000, 3'b011, 32'hC1400000, 3'b001, 2});

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_result", out_result, 32'h0);
      check("reset flags", 32'({out_overflow, out_underflow, out_inexact}), 32'd0);

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], i);

      // Output held under backpressure.
      v = vecs[0];
      start_op(v);
      cyc = 0;
      @(negedge clk);
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d result", i), out_result, 32'h40000000);
         check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("stall release out_valid", 32'(out_valid), 32'd0);
      check("stall release in_ready", 32'(in_ready), 32'd1);

      // Reset aborts an op sitting in SHIFT.
      v = vecs[1];
      start_op(v);
      @(negedge clk);
      check("abort pre in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort out_valid", 32'(out_valid), 32'd0);
      check("abort in_ready", 32'(in_ready), 32'd1);
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) cyc++;
      end
      check("abort no output", 32'(cyc), 32'd0);

      run_vec(vecs[2], 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
